// File: rtl/uart_pkg.sv
// Shared UART transmit definitions: multiplexer select codes,
// controller state encoding and a state-to-select decode helper.
package uart_pkg;

  localparam logic [1:0] SEL_START  = 2'b00;
  localparam logic [1:0] SEL_DATA   = 2'b01;
  localparam logic [1:0] SEL_PARITY = 2'b10;
  localparam logic [1:0] SEL_STOP   = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } tx_state_t;

  function automatic logic [1:0] sel_of(input tx_state_t s);
    logic [1:0] r;
    r = SEL_STOP;
    unique case (s)
      S_START:  r = SEL_START;
      S_DATA:   r = SEL_DATA;
      S_PARITY: r = SEL_PARITY;
      default:  r = SEL_STOP;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period divider: ports clk, rst, en in; bit_tick out, high on
// the last clk cycle of each bit period. Count restarts while en is low.
module uart_baud_gen #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic bit_tick
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign bit_tick = en && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (!en || cnt_q == LAST) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit sequencer driving the bit multiplexer. Ports: clk, rst,
// tx_data/tx_valid/tx_ready handshake; select, data_bit, parity_bit,
// tx_busy, tx_done outputs, all registered.
module uart_tx_ctrl
  import uart_pkg::*;
#(
  parameter int DATA_BITS    = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_EN    = 1,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic [1:0]           select,
  output logic                 data_bit,
  output logic                 parity_bit,
  output logic                 tx_busy,
  output logic                 tx_done
);

  localparam int BC_W = $clog2(DATA_BITS + 1);
  localparam logic [BC_W-1:0] LAST_DATA = BC_W'(DATA_BITS - 1);
  localparam logic [BC_W-1:0] LAST_STOP = BC_W'(STOP_BITS - 1);
  localparam logic ODD = (PARITY_ODD != 0);
  localparam logic PEN = (PARITY_EN != 0);

  tx_state_t            state_q, state_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [BC_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic [1:0]           select_q, select_d;
  logic                 data_bit_q, data_bit_d;
  logic                 parity_q, parity_d;
  logic                 ready_q, ready_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 bit_tick;

  // Divider runs only while a frame is active, so it sits at zero
  // on the handshake edge and START gets a full bit period.
  uart_baud_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk     (clk),
    .rst     (rst),
    .en      (state_q != S_IDLE),
    .bit_tick(bit_tick)
  );

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    parity_d  = parity_q;
    done_d    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (tx_valid && ready_q) begin
          shift_d   = tx_data;
          parity_d  = (^tx_data) ^ ODD;
          bit_cnt_d = '0;
          state_d   = S_START;
        end
      end
      S_START: begin
        if (bit_tick) state_d = S_DATA;
      end
      S_DATA: begin
        if (bit_tick) begin
          if (bit_cnt_q == LAST_DATA) begin
            // No shift here: data_bit keeps the MSB outside DATA.
            bit_cnt_d = '0;
            state_d   = PEN ? S_PARITY : S_STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + BC_W'(1);
            shift_d   = shift_q >> 1;
          end
        end
      end
      S_PARITY: begin
        if (bit_tick) state_d = S_STOP;
      end
      S_STOP: begin
        if (bit_tick) begin
          if (bit_cnt_q == LAST_STOP) begin
            bit_cnt_d = '0;
            state_d   = S_IDLE;
            done_d    = 1'b1;
          end else begin
            bit_cnt_d = bit_cnt_q + BC_W'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Outputs decode the next state so they line up with it.
    select_d   = sel_of(state_d);
    data_bit_d = shift_d[0];
    ready_d    = (state_d == S_IDLE);
    busy_d     = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      select_q   <= SEL_STOP;
      data_bit_q <= 1'b0;
      parity_q   <= 1'b0;
      ready_q    <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      select_q   <= select_d;
      data_bit_q <= data_bit_d;
      parity_q   <= parity_d;
      ready_q    <= ready_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign select     = select_q;
  assign data_bit   = data_bit_q;
  assign parity_bit = parity_q;
  assign tx_ready   = ready_q;
  assign tx_busy    = busy_q;
  assign tx_done    = done_q;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Bench for uart_tx_ctrl: three instances (even parity, odd parity,
// no parity with two stop bits) checked against a frame-timing model.
module tb_uart_tx_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] tx_data;
  logic       v_i    [3];
  logic       rdy_o  [3];
  logic [1:0] sel_o  [3];
  logic       dbit_o [3];
  logic       par_o  [3];
  logic       busy_o [3];
  logic       done_o [3];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  uart_tx_ctrl #(.CLKS_PER_BIT(4)) u_even (
    .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(v_i[0]),
    .tx_ready(rdy_o[0]), .select(sel_o[0]), .data_bit(dbit_o[0]),
    .parity_bit(par_o[0]), .tx_busy(busy_o[0]), .tx_done(done_o[0])
  );

  uart_tx_ctrl #(.CLKS_PER_BIT(4), .PARITY_ODD(1)) u_odd (
    .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(v_i[1]),
    .tx_ready(rdy_o[1]), .select(sel_o[1]), .data_bit(dbit_o[1]),
    .parity_bit(par_o[1]), .tx_busy(busy_o[1]), .tx_done(done_o[1])
  );

  uart_tx_ctrl #(.CLKS_PER_BIT(4), .PARITY_EN(0), .STOP_BITS(2)) u_np (
    .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(v_i[2]),
    .tx_ready(rdy_o[2]), .select(sel_o[2]), .data_bit(dbit_o[2]),
    .parity_bit(par_o[2]), .tx_busy(busy_o[2]), .tx_done(done_o[2])
  );

  function automatic int frame_len(input int w);
    int pen, stp;
    pen = (w == 2) ? 0 : 1;
    stp = (w == 2) ? 2 : 1;
    return (1 + 8 + pen + stp) * 4;
  endfunction

  // Expected outputs c cycles after the handshake edge.
  function automatic void model(
    input int w, input logic [7:0] b, input int c,
    output logic [1:0] s, output logic d, output logic p,
    output logic dn, output logic r
  );
    int pen, L, seg;
    logic odd;
    pen = (w == 2) ? 0 : 1;
    odd = (w == 1);
    L   = frame_len(w);
    p   = (^b) ^ odd;
    d   = b[7];
    dn  = 1'b0;
    r   = 1'b0;
    s   = 2'b11;
    if (c > L) begin
      r  = 1'b1;
      dn = (c == L + 1);
    end else begin
      seg = (c - 1) / 4;
      if (seg == 0) begin
        s = 2'b00;
        d = b[0];
      end else if (seg <= 8) begin
        s = 2'b01;
        d = b[seg-1];
      end else if (seg == 9 && pen == 1) begin
        s = 2'b10;
      end
    end
  endfunction

  task automatic wait_ready(input int w);
    int n = 0;
    while (rdy_o[w] !== 1'b1 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (rdy_o[w] !== 1'b1) begin
      errors++;
      $display("FAIL ready_timeout w%0d got %b want 1", w, rdy_o[w]);
    end
  endtask

  task automatic start_frame(input int w, input logic [7:0] b);
    wait_ready(w);
    tx_data = b;
    v_i[w]  = 1'b1;
  endtask

  // Follows one frame through its tx_done cycle; scrambles inputs
  // mid-frame and presents nxt/hold in the done cycle.
  task automatic check_frame(
    input int w, input logic [7:0] b, input logic [7:0] nxt, input bit hold
  );
    int L;
    logic [1:0] es;
    logic ed, ep, edn, er;
    L = frame_len(w);
    for (int c = 1; c <= L + 1; c++) begin
      @(posedge clk); #1;
      model(w, b, c, es, ed, ep, edn, er);
      checks++;
      if ({sel_o[w], dbit_o[w], par_o[w], done_o[w], rdy_o[w], busy_o[w]}
          !== {es, ed, ep, edn, er, ~er}) begin
        errors++;
        $display("FAIL frame w%0d byte %h c%0d got sel=%b d=%b p=%b done=%b rdy=%b busy=%b want sel=%b d=%b p=%b done=%b rdy=%b busy=%b",
                 w, b, c, sel_o[w], dbit_o[w], par_o[w], done_o[w], rdy_o[w],
                 busy_o[w], es, ed, ep, edn, er, ~er);
      end
      if (c < L) begin
        tx_data = 8'($urandom);
        v_i[w]  = 1'($urandom);
      end else if (c == L) begin
        tx_data = nxt;
        v_i[w]  = hold;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tx_data = 8'h00;
    for (int i = 0; i < 3; i++) v_i[i] = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({sel_o[i], dbit_o[i], par_o[i], rdy_o[i], busy_o[i], done_o[i]}
          !== 7'b11_0_0_1_0_0) begin
        errors++;
        $display("FAIL reset w%0d got sel=%b d=%b p=%b rdy=%b busy=%b done=%b",
                 i, sel_o[i], dbit_o[i], par_o[i], rdy_o[i], busy_o[i], done_o[i]);
      end
    end
  endtask

  task automatic test_single_byte();
    start_frame(0, 8'hA5);
    check_frame(0, 8'hA5, 8'h00, 1'b0);
  endtask

  task automatic test_parity();
    start_frame(0, 8'h01);
    check_frame(0, 8'h01, 8'h00, 1'b0);
    checks++;
    if (par_o[0] !== 1'b1) begin
      errors++;
      $display("FAIL parity_even got %b want 1", par_o[0]);
    end
    start_frame(1, 8'h01);
    check_frame(1, 8'h01, 8'h00, 1'b0);
    checks++;
    if (par_o[1] !== 1'b0) begin
      errors++;
      $display("FAIL parity_odd got %b want 0", par_o[1]);
    end
  endtask

  task automatic test_back_to_back();
    start_frame(0, 8'h3C);
    check_frame(0, 8'h3C, 8'hC3, 1'b1);
    check_frame(0, 8'hC3, 8'($urandom), 1'b0);
  endtask

  task automatic test_reset_mid();
    int bad = 0;
    start_frame(0, 8'h5A);
    for (int c = 1; c <= 10; c++) begin
      @(posedge clk); #1;
      v_i[0] = 1'b0;
      if (c == 10) rst = 1'b1;
    end
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if ({sel_o[0], rdy_o[0], busy_o[0], done_o[0]} !== 5'b11_1_0_0) begin
      errors++;
      $display("FAIL reset_mid got sel=%b rdy=%b busy=%b done=%b want 11 1 0 0",
               sel_o[0], rdy_o[0], busy_o[0], done_o[0]);
    end
    for (int c = 0; c < 60; c++) begin
      @(posedge clk); #1;
      if (done_o[0] !== 1'b0 || sel_o[0] !== 2'b11) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL reset_mid_quiet got %0d bad cycles want 0", bad);
    end
  endtask

  task automatic test_no_parity();
    start_frame(2, 8'hFF);
    check_frame(2, 8'hFF, 8'h00, 1'b0);
  endtask

  task automatic test_random();
    int w;
    logic [7:0] b;
    for (int k = 0; k < 30; k++) begin
      w = $urandom_range(0, 2);
      b = 8'($urandom);
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk); #1;
      end
      start_frame(w, b);
      check_frame(w, b, 8'($urandom), 1'b0);
    end
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_parity();
    test_back_to_back();
    test_reset_mid();
    test_no_parity();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
